mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-port arbiter and sequencer sharing one backing-memory port between the data cache (port 0) and the instruction cache (port 1) inside `memory_controller`. It accepts one request at a time and arbitrates round-robin when both ports request together. It drives a single handshaked memory port and returns read data and a one-cycle acknowledge to the winner. A per-transaction watchdog bounds how long it waits for memory.

## Interface
- `TIMEOUT`, 64: cycles in BUSY without `mem_ready` before the transaction is aborted; valid range 2..255.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `req_0`  in  1  data-cache request; held high until `ack_0`.
- `address_0`  in  32  data-cache address.
- `i_val_0`  in  32  data-cache write data.
- `op_type_0`  in  1  0 = read, 1 = write.
- `ack_0`  out  1  one-cycle completion pulse for port 0.
- `o_val_0`  out  32  read data for port 0.
- `req_1`, `address_1`, `i_val_1`, `op_type_1`, `ack_1`, `o_val_1`: same as port 0, for the instruction cache.
- `mem_req`  out  1  memory request, held until `mem_ready`.
- `mem_address`  out  32  latched address.
- `mem_i_val`  out  32  latched write data.
- `mem_op_type`  out  1  latched operation.
- `mem_ready`  in  1  memory completion, sampled while `mem_req` = 1.
- `mem_o_val`  in  32  memory read data, valid with `mem_ready`.
- `timeout`  out  1  sticky flag: a watchdog abort has occurred.

## Operation
- FSM states and transitions:
  - IDLE: if any `req_N` = 1 at the edge, select the winner, latch its address, write data and op, record the winner in `owner`, and go to BUSY.
  - BUSY: `mem_req` = 1. When `mem_ready` = 1 at an edge, or the watchdog expires, go to ACK.
  - ACK: `ack_owner` = 1 for exactly one cycle, then return to IDLE.
- Arbitration:
  - Only one port requesting: that port wins.
  - Both ports requesting: the port not served last wins.
  - The `last_grant` register updates on entry to BUSY and resets to 1, so port 0 wins the first tie.
- Data return:
  - Read completed by `mem_ready`: `o_val_owner` ← `mem_o_val` on that edge.
  - Write: `o_val_owner` is left unchanged.
  - The other port's `o_val` is never touched.
  - `o_val_N` holds its value until that port's next read completion.
- Watchdog:
  - An 8-bit counter clears on entry to BUSY and increments each BUSY cycle.
  - At count `TIMEOUT`-1 with no `mem_ready`, the transaction aborts: `o_val_owner` ← 0 (read or write), `timeout` ← 1, go to ACK.
  - `mem_ready` and expiry on the same edge: `mem_ready` wins and no timeout is recorded.
- Requester behaviour:
  - `req_N` dropped mid-transaction: ignored; the transaction still completes and `ack_N` still pulses.
  - `req_N` still high in the cycle after ACK: treated as a new request.
  - Changes to `address_N`, `i_val_N` or `op_type_N` after latching: ignored.
- `mem_ready` while not in BUSY: ignored.
- `timeout` is cleared only by reset.

## Timing
- Reset (`rst` = 0, asynchronous) forces:
  - state IDLE; `mem_req`, `ack_0`, `ack_1`, `timeout` = 0;
  - `o_val_0`, `o_val_1`, `mem_address`, `mem_i_val` = 0; `mem_op_type` = 0;
  - `last_grant` = 1; watchdog counter = 0.
- Reset mid-transaction abandons it: no `ack` is issued and `mem_req` drops immediately.
- Release of `rst` is assumed synchronised by the top level.
- All outputs are registered.
- Latency, with `req` high at edge 0:
  - `mem_req` rises after edge 0.
  - If `mem_ready` is sampled at edge k (k ≥ 1), `ack` is high during the cycle after edge k and low after edge k+1.
  - Zero-wait memory gives 3 cycles from request to the end of `ack`.
- Throughput: at most one transaction per 3 cycles.
- Back-to-back ties alternate 0, 1, 0, 1.
- `mem_address`, `mem_i_val` and `mem_op_type` are stable for the whole BUSY interval.

## Test plan
- Reset: hold `rst` = 0 for 3 cycles with both `req` high -> all outputs 0, no `mem_req`. Release -> port 0 granted first.
- Single read on port 1: `address_1` = 0x100, memory responds after 2 wait cycles with 0xCAFEF00D -> `mem_address` = 0x100, `o_val_1` = 0xCAFEF00D, one `ack_1` pulse, `o_val_0` unchanged.
- Tie: `req_0` and `req_1` held high for 4 transactions with zero-wait memory -> grant order 0, 1, 0, 1, each `ack` 1 cycle wide, 3 cycles apart.
- Write on port 0: `address_0` = 0x20, `i_val_0` = 0x12345678, `op_type_0` = 1 -> `mem_i_val` = 0x12345678, `mem_op_type` = 1, `ack_0` pulses, `o_val_0` keeps its previous value.
- Watchdog: `TIMEOUT` = 4, `mem_ready` never asserted -> `ack` after 4 BUSY cycles, `o_val` = 0, `timeout` = 1 and stays 1 through later successful transactions.
- Reset mid-BUSY: assert `rst` = 0 while `mem_req` = 1 -> `mem_req` falls without waiting for a clock edge, no `ack` is produced, and the next request arbitrates normally.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter sharing one handshaked memory port between the
// data cache (port 0) and instruction cache (port 1), with a per-transaction watchdog.
module mem_arbiter #(
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_0,
  input  logic [31:0] address_0,
  input  logic [31:0] i_val_0,
  input  logic        op_type_0,
  output logic        ack_0,
  output logic [31:0] o_val_0,
  input  logic        req_1,
  input  logic [31:0] address_1,
  input  logic [31:0] i_val_1,
  input  logic        op_type_1,
  output logic        ack_1,
  output logic [31:0] o_val_1,
  output logic        mem_req,
  output logic [31:0] mem_address,
  output logic [31:0] mem_i_val,
  output logic        mem_op_type,
  input  logic        mem_ready,
  input  logic [31:0] mem_o_val,
  output logic        timeout
);

  typedef enum logic [1:0] {IDLE, BUSY, ACK} state_t;

  localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);

  state_t      state_q;
  logic        owner_q;
  logic        last_grant_q;
  logic [7:0]  wd_cnt_q;
  logic [1:0]  ack_q;
  logic [31:0] o_val_q [2];
  logic        mem_req_q;
  logic [31:0] mem_address_q;
  logic [31:0] mem_i_val_q;
  logic        mem_op_type_q;
  logic        timeout_q;

  // Winner selection: a lone requester wins; on a tie the port not served last wins.
  logic        grant_d;
  logic        any_req_d;
  logic [31:0] address_d;
  logic [31:0] i_val_d;
  logic        op_type_d;

  always_comb begin
    any_req_d = req_0 | req_1;
    grant_d   = (req_0 & req_1) ? ~last_grant_q : req_1;
    address_d = grant_d ? address_1 : address_0;
    i_val_d   = grant_d ? i_val_1   : i_val_0;
    op_type_d = grant_d ? op_type_1 : op_type_0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      owner_q       <= 1'b0;
      last_grant_q  <= 1'b1;
      wd_cnt_q      <= 8'd0;
      ack_q         <= 2'b00;
      o_val_q[0]    <= 32'd0;
      o_val_q[1]    <= 32'd0;
      mem_req_q     <= 1'b0;
      mem_address_q <= 32'd0;
      mem_i_val_q   <= 32'd0;
      mem_op_type_q <= 1'b0;
      timeout_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          ack_q <= 2'b00;
          if (any_req_d) begin
            owner_q       <= grant_d;
            last_grant_q  <= grant_d;
            mem_address_q <= address_d;
            mem_i_val_q   <= i_val_d;
            mem_op_type_q <= op_type_d;
            mem_req_q     <= 1'b1;
            wd_cnt_q      <= 8'd0;
            state_q       <= BUSY;
          end
        end
        BUSY: begin
          // mem_ready takes priority over a watchdog expiry on the same edge.
          if (mem_ready) begin
            if (!mem_op_type_q) begin
              o_val_q[owner_q] <= mem_o_val;
            end
            ack_q[owner_q] <= 1'b1;
            mem_req_q      <= 1'b0;
            state_q        <= ACK;
          end else if (wd_cnt_q == WD_LAST) begin
            o_val_q[owner_q] <= 32'd0;
            timeout_q        <= 1'b1;
            ack_q[owner_q]   <= 1'b1;
            mem_req_q        <= 1'b0;
            state_q          <= ACK;
          end else begin
            wd_cnt_q <= wd_cnt_q + 8'd1;
          end
        end
        ACK: begin
          ack_q   <= 2'b00;
          state_q <= IDLE;
        end
        default: begin
          ack_q     <= 2'b00;
          mem_req_q <= 1'b0;
          state_q   <= IDLE;
        end
      endcase
    end
  end

  assign ack_0       = ack_q[0];
  assign ack_1       = ack_q[1];
  assign o_val_0     = o_val_q[0];
  assign o_val_1     = o_val_q[1];
  assign mem_req     = mem_req_q;
  assign mem_address = mem_address_q;
  assign mem_i_val   = mem_i_val_q;
  assign mem_op_type = mem_op_type_q;
  assign timeout     = timeout_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized scoreboard bench for mem_arbiter: stimulus predicts each transaction's
// outcome from the arbitration rules and a monitor checks it when ack appears.
module tb_mem_arbiter;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_0, req_1, op_type_0, op_type_1;
  logic [31:0] address_0, address_1, i_val_0, i_val_1;
  logic        ack_0, ack_1;
  logic [31:0] o_val_0, o_val_1;
  logic        mem_req, mem_op_type, mem_ready, timeout;
  logic [31:0] mem_address, mem_i_val, mem_o_val;

  always #5 clk = ~clk;

  mem_arbiter #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .req_0(req_0), .address_0(address_0), .i_val_0(i_val_0), .op_type_0(op_type_0),
    .ack_0(ack_0), .o_val_0(o_val_0),
    .req_1(req_1), .address_1(address_1), .i_val_1(i_val_1), .op_type_1(op_type_1),
    .ack_1(ack_1), .o_val_1(o_val_1),
    .mem_req(mem_req), .mem_address(mem_address), .mem_i_val(mem_i_val),
    .mem_op_type(mem_op_type), .mem_ready(mem_ready), .mem_o_val(mem_o_val),
    .timeout(timeout)
  );

  typedef struct {
    bit          port;
    logic [31:0] addr;
    logic [31:0] wdata;
    bit          op;
    logic [31:0] oval0;
    logic [31:0] oval1;
    bit          to;
    int          lat;
  } exp_t;

  exp_t        exp_q[$];
  int          lat_q[$];
  logic [31:0] mdata_q[$];
  int          n_checks = 0;
  int          n_err = 0;

  bit          pend [2];
  logic [31:0] p_addr [2];
  logic [31:0] p_data [2];
  bit          p_op [2];

  bit          m_last;
  logic [31:0] m_oval [2];
  bit          m_to;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic drive_port(input int p, input bit r);
    if (p == 0) begin
      req_0 = r; address_0 = p_addr[0]; i_val_0 = p_data[0]; op_type_0 = p_op[0];
    end else begin
      req_1 = r; address_1 = p_addr[1]; i_val_1 = p_data[1]; op_type_1 = p_op[1];
    end
  endtask

  task automatic new_req(input int p);
    pend[p]   = 1'b1;
    p_addr[p] = $urandom;
    p_data[p] = $urandom;
    p_op[p]   = 1'($urandom_range(0, 1));
    drive_port(p, 1'b1);
  endtask

  task automatic model_reset();
    m_last    = 1'b1;
    m_oval[0] = 32'd0;
    m_oval[1] = 32'd0;
    m_to      = 1'b0;
  endtask

  // Decide the winner and outcome of the next transaction from the rules alone.
  task automatic start_round(output bit w);
    exp_t        e;
    int          lat;
    logic [31:0] d;
    if (!pend[0] && !pend[1]) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      new_req(int'($urandom_range(0, 1)));
    end
    w      = (pend[0] && pend[1]) ? !m_last : pend[1];
    m_last = w;
    lat    = int'($urandom_range(1, TO + 2));
    d      = $urandom;
    e.port = w; e.addr = p_addr[w]; e.wdata = p_data[w]; e.op = p_op[w];
    if (lat <= TO) begin
      if (!p_op[w]) m_oval[w] = d;
      e.lat = lat;
    end else begin
      m_oval[w] = 32'd0;
      m_to      = 1'b1;
      e.lat     = TO;
    end
    e.oval0 = m_oval[0]; e.oval1 = m_oval[1]; e.to = m_to;
    exp_q.push_back(e);
    lat_q.push_back(lat);
    mdata_q.push_back(d);
  endtask

  task automatic wait_ack(input bit w);
    bit got = 1'b0;
    for (int i = 0; i < TO + 12; i++) begin
      @(negedge clk);
      if (w ? ack_1 : ack_0) begin
        got = 1'b1;
        break;
      end
      // Latched fields must not follow later input changes or a dropped request.
      if (mem_req && $urandom_range(0, 3) == 0) begin
        p_addr[w] = $urandom; p_data[w] = $urandom; p_op[w] = 1'($urandom_range(0, 1));
        drive_port(int'(w), 1'($urandom_range(0, 1)));
      end
    end
    check("ack_arrived", {31'd0, got}, 32'd1);
    pend[w] = 1'b0;
    drive_port(int'(w), 1'b0);
  endtask

  task automatic run_rounds(input int n);
    bit w;
    for (int r = 0; r < n; r++) begin
      for (int p = 0; p < 2; p++)
        if (!pend[p] && $urandom_range(0, 2) != 0) new_req(p);
      start_round(w);
      wait_ack(w);
    end
    for (int p = 0; p < 2; p++) begin
      pend[p] = 1'b0;
      drive_port(p, 1'b0);
    end
  endtask

  // Memory model: answers after the planned number of BUSY cycles, noise otherwise.
  initial begin
    bit          active = 1'b0;
    int          cnt = 0;
    int          lat = 0;
    logic [31:0] d = 32'd0;
    mem_ready = 1'b0;
    mem_o_val = 32'd0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        active = 1'b0;
        mem_ready = 1'b0;
      end else if (mem_req) begin
        if (!active) begin
          active = 1'b1;
          cnt = 0;
          lat = (lat_q.size() > 0) ? lat_q.pop_front() : 1000;
          d   = (mdata_q.size() > 0) ? mdata_q.pop_front() : 32'd0;
        end
        cnt++;
        mem_ready = (cnt == lat);
        mem_o_val = (cnt == lat) ? d : $urandom;
      end else begin
        active = 1'b0;
        mem_ready = 1'($urandom_range(0, 1));
        mem_o_val = $urandom;
      end
    end
  end

  // Monitor: checks latched request while BUSY and the full outcome on each ack.
  initial begin
    int   busy_cnt = 0;
    bit   prev_ack = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        busy_cnt = 0;
        prev_ack = 1'b0;
      end else begin
        if (mem_req) begin
          busy_cnt++;
          if (exp_q.size() == 0) begin
            check("mem_req_unexpected", {31'd0, mem_req}, 32'd0);
          end else begin
            check("mem_address", mem_address, exp_q[0].addr);
            check("mem_i_val", mem_i_val, exp_q[0].wdata);
            check("mem_op_type", {31'd0, mem_op_type}, {31'd0, exp_q[0].op});
          end
        end
        if (ack_0 || ack_1) begin
          check("ack_one_port", {30'd0, ack_1, ack_0} & 32'd3, ack_1 ? 32'd2 : 32'd1);
          check("ack_width", {31'd0, prev_ack}, 32'd0);
          check("mem_req_in_ack", {31'd0, mem_req}, 32'd0);
          if (exp_q.size() == 0) begin
            check("ack_unexpected", 32'd1, 32'd0);
          end else begin
            e = exp_q.pop_front();
            check("ack_port", {31'd0, ack_1}, {31'd0, e.port});
            check("o_val_0", o_val_0, e.oval0);
            check("o_val_1", o_val_1, e.oval1);
            check("timeout", {31'd0, timeout}, {31'd0, e.to});
            check("busy_cycles", busy_cnt, e.lat);
            $display("txn port=%0d addr=%h op=%0d busy=%0d o_val0=%h o_val1=%h timeout=%0d",
                     e.port, e.addr, e.op, busy_cnt, o_val_0, o_val_1, timeout);
          end
          busy_cnt = 0;
        end
        prev_ack = ack_0 || ack_1;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    bit w;
    rst = 1'b0;
    model_reset();
    new_req(0);
    new_req(1);
    repeat (3) @(negedge clk);
    check("rst_mem_req", {31'd0, mem_req}, 32'd0);
    check("rst_acks", {30'd0, ack_1, ack_0}, 32'd0);
    check("rst_timeout", {31'd0, timeout}, 32'd0);
    check("rst_o_val_0", o_val_0, 32'd0);
    check("rst_o_val_1", o_val_1, 32'd0);
    check("rst_mem_address", mem_address, 32'd0);
    check("rst_mem_i_val", mem_i_val, 32'd0);
    check("rst_mem_op_type", {31'd0, mem_op_type}, 32'd0);
    rst = 1'b1;
    run_rounds(150);

    // Reset in the middle of a BUSY interval.
    new_req(int'($urandom_range(0, 1)));
    start_round(w);
    for (int i = 0; i < 10 && !mem_req; i++) @(negedge clk);
    check("midrst_busy", {31'd0, mem_req}, 32'd1);
    #2 rst = 1'b0;
    #1;
    check("midrst_mem_req", {31'd0, mem_req}, 32'd0);
    check("midrst_acks", {30'd0, ack_1, ack_0}, 32'd0);
    check("midrst_timeout", {31'd0, timeout}, 32'd0);
    exp_q.delete();
    lat_q.delete();
    mdata_q.delete();
    for (int p = 0; p < 2; p++) begin
      pend[p] = 1'b0;
      drive_port(p, 1'b0);
    end
    model_reset();
    repeat (2) @(negedge clk);
    check("midrst_no_ack", {30'd0, ack_1, ack_0}, 32'd0);
    rst = 1'b1;
    run_rounds(40);

    repeat (4) @(negedge clk);
    check("queue_drained", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
